// File: rtl/arbiter_pkg.sv
// arbiter_pkg: frame codes, command codes and TX states for the master/arbiter serial link
package arbiter_pkg;
    typedef enum logic [1:0] {REQ = 2'b01, DONE = 2'b10} tx_code_t;
    typedef enum logic [1:0] {START = 2'b01, STOP = 2'b10} arb_cmd_t;
    localparam logic START_BIT = 1'b1;
    localparam int CMD_LEN = 3;
    typedef enum logic [2:0] {IDLE, SEND_REQ, WAIT_GRANT, GRANTED, SEND_DONE} tx_state_t;
endpackage

// File: rtl/link_cmd_rx.sv
// link_cmd_rx: 3-bit command deserializer, cmd_valid is high during the last command bit
module link_cmd_rx
    import arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       port_in,
    output logic       cmd_valid,
    output logic [1:0] cmd
);
    typedef enum logic [1:0] {RX_IDLE, RX_B1, RX_B0} rx_state_t;
    rx_state_t state, state_next;
    logic msb;
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= RX_IDLE;
            msb   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == RX_B1) msb <= port_in;
        end
    end
    always_comb begin
        state_next = state == RX_IDLE ? (port_in == START_BIT ? RX_B1 : RX_IDLE)
                   : state == RX_B1   ? RX_B0 : RX_IDLE;
    end
    // Decoding on the final bit lets the owner register the effect at t+3
    assign cmd_valid = state == RX_B0;
    assign cmd       = {msb, port_in};
endmodule

// File: rtl/master_arbiter_link.sv
// master_arbiter_link: master-side serial link to the bus arbiter (REQ/DONE out, START/STOP in)
module master_arbiter_link
    import arbiter_pkg::*;
#(
    parameter int NO_SLAVES  = 3,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  port_in,
    output logic                  port_out,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] slave_id,
    input  logic                  done,
    output logic                  granted,
    output logic                  preempted,
    output logic                  busy,
    output logic                  proto_err
);
    localparam int F  = 3 + S_ID_WIDTH;
    localparam int BW = $clog2(F);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    tx_state_t state, state_next;
    logic [F-1:0]          sh, sh_next;
    logic [BW-1:0]         bcnt, bcnt_next;
    logic [TW-1:0]         tcnt, tcnt_next;
    logic [S_ID_WIDTH-1:0] id, id_next;
    logic pend, pend_next, pre_next, err_next;
    logic cmd_valid, is_start, is_stop, is_rsvd, last, timed_out;
    logic [1:0] cmd;

    link_cmd_rx u_rx (
        .clk       (clk),
        .rstN      (rstN),
        .port_in   (port_in),
        .cmd_valid (cmd_valid),
        .cmd       (cmd)
    );

    assign is_start  = cmd_valid && cmd == START;
    assign is_stop   = cmd_valid && cmd == STOP;
    assign is_rsvd   = cmd_valid && (cmd == 2'b00 || cmd == 2'b11);
    assign last      = bcnt == BW'(F - 1);
    assign timed_out = TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= IDLE;
            sh        <= '0;
            bcnt      <= '0;
            tcnt      <= '0;
            id        <= '0;
            pend      <= 1'b0;
            preempted <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            sh        <= sh_next;
            bcnt      <= bcnt_next;
            tcnt      <= tcnt_next;
            id        <= id_next;
            pend      <= pend_next;
            preempted <= pre_next;
            proto_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        sh_next    = sh;
        bcnt_next  = bcnt;
        tcnt_next  = tcnt;
        id_next    = id;
        pend_next  = pend;
        pre_next   = 1'b0;
        // START is legitimate while waiting or while (re)sending the request
        err_next   = is_rsvd || (is_start && state != WAIT_GRANT && state != SEND_REQ);
        case (state)
            IDLE: if (req) begin
                state_next = SEND_REQ;
                id_next    = slave_id;
                sh_next    = {START_BIT, REQ, slave_id};
                bcnt_next  = '0;
            end
            SEND_REQ: begin
                sh_next   = sh << 1;
                bcnt_next = bcnt + 1'b1;
                pend_next = pend | is_start;
                if (last) begin
                    state_next = (pend || is_start) ? GRANTED : WAIT_GRANT;
                    tcnt_next  = '0;
                    pend_next  = 1'b0;
                end
            end
            WAIT_GRANT: begin
                if (is_start) state_next = GRANTED;
                else if (timed_out) begin
                    state_next = SEND_REQ;
                    sh_next    = {START_BIT, REQ, id};
                    bcnt_next  = '0;
                end else if (tcnt != TW'(TIMEOUT)) tcnt_next = tcnt + 1'b1;
            end
            GRANTED: begin
                if (is_stop) begin
                    state_next = IDLE;
                    pre_next   = 1'b1;
                end else if (done) begin
                    state_next = SEND_DONE;
                    sh_next    = {START_BIT, DONE, {S_ID_WIDTH{1'b0}}};
                    bcnt_next  = '0;
                end
            end
            SEND_DONE: begin
                sh_next   = sh << 1;
                bcnt_next = bcnt + 1'b1;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign port_out = (state == SEND_REQ || state == SEND_DONE) && sh[F-1];
    assign granted  = state == GRANTED;
    assign busy     = state != IDLE;
endmodule

// File: tb/tb_master_arbiter_link.sv
// tb_master_arbiter_link: directed checks of framing, grant/preempt handshake, retry and reset
module tb_master_arbiter_link;
    logic clk = 1'b0;
    logic rstN, port_in, port_out, req, done, granted, preempted, busy, proto_err;
    logic [1:0] slave_id;
    int n_checks = 0;
    int n_fail = 0;

    master_arbiter_link #(.NO_SLAVES(3), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .port_in   (port_in),
        .port_out  (port_out),
        .req       (req),
        .slave_id  (slave_id),
        .done      (done),
        .granted   (granted),
        .preempted (preempted),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] c);
        port_in = 1'b1;
        tick();
        port_in = c[1];
        tick();
        port_in = c[0];
        tick();
        port_in = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [4:0] bits);
        for (int i = 4; i >= 0; i--) begin
            check(tag, port_out, bits[i]);
            check({tag, "_busy"}, busy, 1);
            tick();
        end
    endtask

    initial begin
        rstN = 1'b0; port_in = 1'b0; req = 1'b0; done = 1'b0; slave_id = 2'd0;
        tick();
        tick();
        check("rst_port_out", port_out, 0);
        check("rst_granted", granted, 0);
        check("rst_busy", busy, 0);
        check("rst_preempted", preempted, 0);
        check("rst_proto_err", proto_err, 0);
        rstN = 1'b1;
        tick();

        // Request frame for slave 2
        req = 1'b1; slave_id = 2'd2;
        tick();
        req = 1'b0;
        check_frame("req_frame", 5'b10110);
        check("req_gap", port_out, 0);
        check("req_wait_busy", busy, 1);

        // Grant: visible exactly three cycles after the start bit
        port_in = 1'b1;
        tick();
        port_in = 1'b0;
        tick();
        port_in = 1'b1;
        check("grant_early", granted, 0);
        tick();
        port_in = 1'b0;
        check("grant", granted, 1);
        check("grant_err", proto_err, 0);

        // Release through a DONE frame
        done = 1'b1;
        tick();
        done = 1'b0;
        check("release_granted", granted, 0);
        check_frame("done_frame", 5'b11000);
        check("release_busy", busy, 0);
        check("release_port_out", port_out, 0);

        // STOP while idle is silently ignored
        send_cmd(2'b10);
        check("stop_idle_err", proto_err, 0);
        check("stop_idle_pre", preempted, 0);

        // Preempt with done on the decode cycle
        req = 1'b1; slave_id = 2'd3;
        tick();
        req = 1'b0;
        check_frame("req3_frame", 5'b10111);
        send_cmd(2'b01);
        check("grant2", granted, 1);
        port_in = 1'b1;
        tick();
        tick();
        port_in = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("preempt_pulse", preempted, 1);
        check("preempt_granted", granted, 0);
        check("preempt_busy", busy, 0);
        tick();
        check("preempt_pulse_end", preempted, 0);
        for (int i = 0; i < 6; i++) begin
            check("preempt_no_done", port_out, 0);
            tick();
        end

        // Timeout retry with START arriving during the retransmission
        req = 1'b1; slave_id = 2'd1;
        tick();
        req = 1'b0; slave_id = 2'd3;
        check_frame("to_frame1", 5'b10101);
        for (int i = 0; i < 8; i++) begin
            check("to_wait", port_out, 0);
            check("to_wait_busy", busy, 1);
            tick();
        end
        for (int i = 4; i >= 0; i--) begin
            port_in = (i == 4 || i == 2);
            check("to_frame2", port_out, (i == 4 || i == 2 || i == 0) ? 1 : 0);
            check("to_frame2_granted", granted, 0);
            tick();
        end
        port_in = 1'b0;
        check("to_granted", granted, 1);
        check("to_err", proto_err, 0);
        send_cmd(2'b10);
        check("to_preempt", preempted, 1);
        tick();

        // Unexpected START and a reserved code while idle
        send_cmd(2'b01);
        check("start_idle_err", proto_err, 1);
        check("start_idle_busy", busy, 0);
        tick();
        check("start_idle_err_end", proto_err, 0);
        send_cmd(2'b11);
        check("rsvd_err", proto_err, 1);
        tick();

        // Reset in the middle of a REQ frame
        req = 1'b1; slave_id = 2'd2;
        tick();
        req = 1'b0;
        tick();
        tick();
        check("mid_frame_bit2", port_out, 1);
        rstN = 1'b0;
        tick();
        check("mid_rst_port_out", port_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_granted", granted, 0);
        check("mid_rst_err", proto_err, 0);
        rstN = 1'b1;
        tick();
        check("post_rst_port_out", port_out, 0);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/master_arbiter_link.md
Name: master_arbiter_link

Overview:
- Master-side end of the 1-bit serial link into the bus arbiter.
- Serializes the master's bus requests and completion notices onto port_out.
- Deserializes arbiter commands (START / STOP) arriving on port_in and exposes them as a clean grant/preempt handshake to the master's bus FSM.
- One instance per master, placed between the master core and the arbiter's per-master port.

Parameters:
- NO_SLAVES, 3, number of slaves on the bus.
- S_ID_WIDTH, $clog2(NO_SLAVES+1), width of the slave id field.
- TIMEOUT, 1024, cycles to wait in WAIT_GRANT before re-sending REQ; 0 disables retry.

Ports:
- clk  in  1  system clock.
- rstN  in  1  synchronous, active-low reset (one clock; sync active-low fixed).
- port_in  in  1  serial commands from arbiter.
- port_out  out  1  serial frames to arbiter.
- req  in  1  master requests bus (level, sampled in IDLE only).
- slave_id  in  S_ID_WIDTH  target slave, captured with req.
- done  in  1  one-cycle pulse: transaction finished, release bus.
- granted  out  1  high while master owns bus.
- preempted  out  1  one-cycle pulse: grant revoked by STOP.
- busy  out  1  high in any state except IDLE.
- proto_err  out  1  one-cycle pulse on unexpected command.

Behaviour:
- Reset: all outputs 0; TX FSM = IDLE; RX = RX_IDLE; counters cleared. Reset mid-frame forces port_out=0 from the next edge.
- TX frame, F = 3+S_ID_WIDTH cycles, MSB first: start bit 1, 2-bit code, then id (zeros for non-REQ). Codes: REQ=2'b01, DONE=2'b10.
- port_out idles low. The FSM guarantees at least one low cycle between frames.
- RX frame, 3 cycles: start bit 1, 2-bit cmd MSB first. Codes: START=2'b01, STOP=2'b10; 2'b00 and 2'b11 are reserved and raise proto_err.
- RX latency: start at cycle t, cmd bits t+1 and t+2, decoded effect visible on outputs at t+3. RX returns to RX_IDLE at t+3 and may accept a new start bit in the same cycle.
- TX FSM transitions:
  - IDLE -> SEND_REQ when req=1; latch slave_id.
  - SEND_REQ -> WAIT_GRANT after the last bit; timeout counter clears.
  - WAIT_GRANT: on START -> GRANTED (granted=1). If TIMEOUT!=0 and the counter reaches TIMEOUT-1 -> SEND_REQ (same id).
  - GRANTED: on done=1 -> SEND_DONE (granted=0 the next cycle). On STOP -> IDLE, granted=0, preempted=1 for one cycle, no DONE frame.
  - SEND_DONE -> IDLE after the last bit.
- Boundary cases:
  - START outside WAIT_GRANT: ignored, proto_err pulse.
  - STOP outside GRANTED: ignored, no pulse.
  - START decoded while SEND_REQ is retransmitting: accepted after the frame completes; pending flag held one frame max.
  - STOP and done in the same cycle: STOP wins, no DONE frame sent.
  - req held high after DONE/STOP: a new REQ frame starts from IDLE on the next cycle; no stale id is used.
  - Timeout counter width is $clog2(TIMEOUT+1) and saturates; it never wraps.

Decomposition:
- arbiter_pkg holds:
  - Enum tx_code_t {REQ, DONE}.
  - Enum arb_cmd_t {START, STOP}.
  - Localparams for the frame start-bit value and command length.
  - TX state enum.
- Sub-module link_cmd_rx: 3-bit deserializer emitting a one-cycle cmd_valid plus cmd[1:0]. It is reusable for the arbiter-side receive path.

Test Plan:
- Request frame (NO_SLAVES=3, req=1, slave_id=2 from IDLE) -> port_out sequence 1,0,1,1,0 over 5 cycles, then 0; busy=1.
- Grant: after the request frame, drive port_in 1,0,1 -> granted=1 exactly 3 cycles after the start bit; proto_err=0.
- Release: with granted=1, pulse done -> granted=0 the next cycle, then port_out 1,1,0,0,0, then IDLE, busy=0.
- Preempt with simultaneous done: in GRANTED, drive STOP (1,1,0) with done pulsed on the decode cycle -> preempted pulse, granted=0, no DONE frame on port_out.
- Timeout retry: TIMEOUT=8 with no START -> REQ frame retransmitted 8 cycles after the first frame ends. Send START during the retransmit -> granted=1 right after that frame ends.
- Error and reset: START while IDLE -> proto_err pulse, state unchanged. rstN=0 on bit 2 of a REQ frame -> port_out=0 on the next edge, all outputs 0.
